// File: rtl/pattern_count_sequencer.sv
`timescale 1ns/1ps
// Run controller for the pattern-count datapath: synchronises SignalIn, samples it at a
// prescaled rate, matches a sliding window against a latched pattern and counts to a target.
module pattern_count_sequencer #(
    parameter int PATTERN_WIDTH = 3,
    parameter int COUNT_WIDTH   = 10,
    parameter int SAMPLE_DIV    = 4
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic                     SignalIn,
    input  logic                     SignalEnable,
    input  logic [PATTERN_WIDTH-1:0] PatternIn,
    input  logic [COUNT_WIDTH-1:0]   PatternCountTarget,
    input  logic                     Start,
    input  logic                     Abort,
    input  logic                     IrqEnable,
    input  logic                     IrqClear,
    output logic                     SignalOut,
    output logic [COUNT_WIDTH-1:0]   PatternCountTotal,
    output logic                     PatternCountDone,
    output logic                     Busy,
    output logic                     PatternCountDone_interrupt,
    output logic [1:0]               debug_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int PS_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int FILL_W = (PATTERN_WIDTH > 2) ? $clog2(PATTERN_WIDTH) : 1;
    localparam logic [PS_W-1:0]        PS_LAST   = PS_W'(SAMPLE_DIV - 1);
    localparam logic [FILL_W-1:0]      FILL_LAST = FILL_W'(PATTERN_WIDTH - 2);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [1:0]               state;
    logic [1:0]               state_next;
    logic                     sync_meta;
    logic                     sync_in;
    logic [PS_W-1:0]          ps_cnt;
    logic [FILL_W-1:0]        fill_cnt;
    logic [PATTERN_WIDTH-2:0] hist;
    logic [PATTERN_WIDTH-1:0] win_next;
    logic [PATTERN_WIDTH-1:0] pat_q;
    logic [COUNT_WIDTH-1:0]   tgt_q;
    logic [COUNT_WIDTH-1:0]   count_q;
    logic [COUNT_WIDTH-1:0]   count_inc;
    logic                     sig_q;
    logic                     irq_q;
    logic                     start_ok;
    logic                     active;
    logic                     tick;
    logic                     match;
    logic                     final_hit;
    logic                     done_entry;

    // Start, Abort and IrqClear are single-cycle pulses acted on at the next rising edge;
    // Abort dominates Start, and Start is only accepted from IDLE or DONE.
    assign start_ok  = Start & ~Abort & ((state == ST_IDLE) | (state == ST_DONE));
    assign active    = ((state == ST_ARM) | (state == ST_RUN)) & SignalEnable;
    assign tick      = active & (ps_cnt == PS_LAST);

    // The full window is {hist, sync_in}; only the PW-1 newest samples need storing
    // because the oldest one drops out on the same tick that the comparison uses.
    assign win_next  = {hist, sync_in};
    assign match     = (state == ST_RUN) & tick & (win_next == pat_q);
    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
    assign final_hit = match & (count_inc == tgt_q);

    always_comb begin
        state_next = state;
        if (Abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) state_next = (PatternCountTarget == '0) ? ST_DONE : ST_ARM;
                end
                ST_ARM: begin
                    if (tick && (fill_cnt == FILL_LAST)) state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (final_hit) state_next = ST_DONE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A zero-target restart from DONE re-enters DONE and counts as a completion.
    assign done_entry = (state_next == ST_DONE) & ((state != ST_DONE) | start_ok);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            sync_meta <= 1'b0;
            sync_in   <= 1'b0;
        end else begin
            sync_meta <= SignalIn;
            sync_in   <= sync_meta;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ps_cnt   <= '0;
            fill_cnt <= '0;
        end else if (start_ok) begin
            ps_cnt   <= '0;
            fill_cnt <= '0;
        end else if (active) begin
            ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
            if (tick && (state == ST_ARM)) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            hist <= '0;
        end else if (Abort || start_ok) begin
            hist <= '0;
        end else if (tick) begin
            hist <= win_next[PATTERN_WIDTH-2:0];
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pat_q <= '0;
            tgt_q <= '0;
        end else if (start_ok) begin
            pat_q <= PatternIn;
            tgt_q <= PatternCountTarget;
        end
    end

    // Count is held across Abort so software can still read the partial result.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            count_q <= '0;
            sig_q   <= 1'b0;
        end else begin
            sig_q <= match & ~Abort;
            if (start_ok) begin
                count_q <= '0;
            end else if (match && !Abort) begin
                count_q <= count_inc;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            irq_q <= 1'b0;
        end else if (done_entry && IrqEnable) begin
            irq_q <= 1'b1;
        end else if (IrqClear) begin
            irq_q <= 1'b0;
        end
    end

    assign SignalOut                  = sig_q;
    assign PatternCountTotal          = count_q;
    assign PatternCountDone           = (state == ST_DONE);
    assign Busy                       = (state == ST_ARM) | (state == ST_RUN);
    assign PatternCountDone_interrupt = irq_q;
    assign debug_state                = state;

endmodule

// File: tb/tb_pattern_count_sequencer.sv
`timescale 1ns/1ps
// Directed bench for pattern_count_sequencer: per-cycle vector table on a SAMPLE_DIV=1 instance,
// plus hand-written reset and prescaled-sampling sequences on a SAMPLE_DIV=4 instance.
module tb_pattern_count_sequencer;

    localparam int PW = 3;
    localparam int CW = 10;
    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] ARM = 2'd1;
    localparam logic [1:0] RUN = 2'd2;
    localparam logic [1:0] DON = 2'd3;

    typedef struct {
        logic          start;
        logic          abort;
        logic          en;
        logic          sin;
        logic [PW-1:0] pat;
        logic [CW-1:0] tgt;
        logic          ie;
        logic          ic;
        logic          so;
        logic [CW-1:0] cnt;
        logic          done;
        logic          busy;
        logic          irq;
        logic [1:0]    st;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sig_in = 1'b0;
    logic          sig_en = 1'b0;
    logic [PW-1:0] pat_in = '0;
    logic [CW-1:0] tgt_in = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          irq_en = 1'b0;
    logic          irq_clr = 1'b0;

    logic          so1, done1, busy1, irq1;
    logic [CW-1:0] cnt1;
    logic [1:0]    st1;
    logic          so4, done4, busy4, irq4;
    logic [CW-1:0] cnt4;
    logic [1:0]    st4;

    int            n_checks = 0;
    int            n_fail = 0;
    logic          mon_en = 1'b0;
    logic [CW-1:0] exp_q[$];
    vec_t          vecs[$];

    pattern_count_sequencer #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(CW), .SAMPLE_DIV(1)) dut1 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .SignalIn(sig_in), .SignalEnable(sig_en),
        .PatternIn(pat_in), .PatternCountTarget(tgt_in), .Start(start), .Abort(abort),
        .IrqEnable(irq_en), .IrqClear(irq_clr), .SignalOut(so1), .PatternCountTotal(cnt1),
        .PatternCountDone(done1), .Busy(busy1), .PatternCountDone_interrupt(irq1),
        .debug_state(st1)
    );

    pattern_count_sequencer #(.PATTERN_WIDTH(PW), .COUNT_WIDTH(CW), .SAMPLE_DIV(4)) dut4 (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .SignalIn(sig_in), .SignalEnable(sig_en),
        .PatternIn(pat_in), .PatternCountTarget(tgt_in), .Start(start), .Abort(abort),
        .IrqEnable(irq_en), .IrqClear(irq_clr), .SignalOut(so4), .PatternCountTotal(cnt4),
        .PatternCountDone(done4), .Busy(busy4), .PatternCountDone_interrupt(irq4),
        .debug_state(st4)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic void add(input int s, input int a, input int e, input int si,
                                input int p, input int t, input int ie, input int ic,
                                input int so, input int c, input int d, input int b,
                                input int q, input logic [1:0] st);
        vec_t v;
        v.start = 1'(s);  v.abort = 1'(a);  v.en = 1'(e);   v.sin = 1'(si);
        v.pat   = PW'(p); v.tgt   = CW'(t); v.ie = 1'(ie);  v.ic  = 1'(ic);
        v.so    = 1'(so); v.cnt   = CW'(c); v.done = 1'(d); v.busy = 1'(b);
        v.irq   = 1'(q);  v.st    = st;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        start = v.start; abort = v.abort; sig_en = v.en; sig_in = v.sin;
        pat_in = v.pat;  tgt_in = v.tgt;  irq_en = v.ie; irq_clr = v.ic;
    endtask

    // Scoreboard: every SignalOut pulse of the SAMPLE_DIV=1 instance must carry the next expected count.
    always @(negedge clk) begin
        if (mon_en && rst_n && so1) begin
            if (exp_q.size() == 0) begin
                check("pulse_unexpected", 32'(cnt1), 32'hFFFF_FFFF);
            end else begin
                check("pulse_count", 32'(cnt1), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Pattern 101, target 2, serial 1,0,1,0,1 (two cycles of sync latency), IrqEnable=1.
        add(0,0,1,1,5,2,1,0, 0,0,0,0,0,IDL);
        add(1,0,1,0,5,2,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,5,2,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,0,5,2,1,0, 0,0,0,1,0,RUN);
        add(0,0,1,1,5,2,1,0, 1,1,0,1,0,RUN);
        add(0,0,1,0,5,2,1,0, 0,1,0,1,0,RUN);
        add(0,0,1,0,5,2,1,0, 1,2,1,0,1,DON);
        add(0,0,1,0,5,2,1,0, 0,2,1,0,1,DON);
        add(0,0,1,0,5,2,1,1, 0,2,1,0,0,DON);
        // Same run restarted from DONE with IrqEnable=0.
        add(0,0,1,1,5,2,0,0, 0,2,1,0,0,DON);
        add(1,0,1,0,5,2,0,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,5,2,0,0, 0,0,0,1,0,ARM);
        add(0,0,1,0,5,2,0,0, 0,0,0,1,0,RUN);
        add(0,0,1,1,5,2,0,0, 1,1,0,1,0,RUN);
        add(0,0,1,0,5,2,0,0, 0,1,0,1,0,RUN);
        add(0,0,1,0,5,2,0,0, 1,2,1,0,0,DON);
        add(0,0,1,0,5,2,0,0, 0,2,1,0,0,DON);
        // Target 0: straight to DONE, never busy.
        add(0,1,1,0,5,0,0,0, 0,2,0,0,0,IDL);
        add(1,0,1,0,5,0,1,0, 0,0,1,0,1,DON);
        add(0,0,1,0,5,0,1,0, 0,0,1,0,1,DON);
        add(0,0,1,0,5,0,1,1, 0,0,1,0,0,DON);
        // IrqClear on the DONE-entry edge loses to the set; IrqEnable=0 keeps a pending flag.
        add(0,1,1,1,5,0,1,0, 0,0,0,0,0,IDL);
        add(1,0,1,1,5,0,1,1, 0,0,1,0,1,DON);
        add(0,0,1,1,5,0,0,0, 0,0,1,0,1,DON);
        add(0,0,1,1,5,0,0,1, 0,0,1,0,0,DON);
        // Pattern 111, target 5, stream of 1s, 10-cycle enable gap.
        add(1,0,1,1,7,5,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,7,5,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,7,5,1,0, 0,0,0,1,0,RUN);
        add(0,0,1,1,7,5,1,0, 1,1,0,1,0,RUN);
        add(0,0,1,1,7,5,1,0, 1,2,0,1,0,RUN);
        add(0,0,1,1,7,5,1,0, 1,3,0,1,0,RUN);
        for (int g = 0; g < 10; g++) add(0,0,0,1,7,5,1,0, 0,3,0,1,0,RUN);
        add(0,0,1,1,7,5,1,0, 1,4,0,1,0,RUN);
        add(0,0,1,1,7,5,1,0, 1,5,1,0,1,DON);
        add(0,0,1,1,7,5,1,1, 0,5,1,0,0,DON);
        // Rerun with live pattern/target changed, Start ignored in RUN, then Abort+Start.
        add(1,0,1,1,7,5,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,0,1,1,0, 0,0,0,1,0,ARM);
        add(0,0,1,1,0,1,1,0, 0,0,0,1,0,RUN);
        add(1,0,1,1,0,1,1,0, 1,1,0,1,0,RUN);
        add(0,0,1,1,0,1,1,0, 1,2,0,1,0,RUN);
        add(1,1,1,1,7,5,1,0, 0,2,0,0,0,IDL);
        add(0,0,1,1,7,5,1,0, 0,2,0,0,0,IDL);
        exp_q = '{10'd1, 10'd2, 10'd1, 10'd2, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd1, 10'd2, 10'd1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut1", 32'({so1, cnt1, done1, busy1, irq1, st1}), 32'd0);
        check("reset_dut4", 32'({so4, cnt4, done4, busy4, irq4, st4}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.sig_out", i), 32'(so1),   32'(vecs[i].so));
            check($sformatf("v%0d.count", i),   32'(cnt1),  32'(vecs[i].cnt));
            check($sformatf("v%0d.done", i),    32'(done1), 32'(vecs[i].done));
            check($sformatf("v%0d.busy", i),    32'(busy1), 32'(vecs[i].busy));
            check($sformatf("v%0d.irq", i),     32'(irq1),  32'(vecs[i].irq));
            check($sformatf("v%0d.state", i),   32'(st1),   32'(vecs[i].st));
        end

        // Asynchronous reset in the middle of a run
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            start = (k == 0); abort = 1'b0; sig_en = 1'b1; sig_in = 1'b1;
            pat_in = 3'b111; tgt_in = 10'd5; irq_en = 1'b1; irq_clr = 1'b0;
            @(posedge clk);
            #1;
        end
        check("rst_pre_count", 32'(cnt1), 32'd1);
        check("rst_pre_state", 32'(st1), 32'(RUN));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_dut1", 32'({so1, cnt1, done1, busy1, irq1, st1}), 32'd0);
        check("rst_async_dut4", 32'({so4, cnt4, done4, busy4, irq4, st4}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0; sig_in = 1'b0; irq_en = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_state", 32'(st1), 32'(IDL));
        check("rst_release_count", 32'(cnt1), 32'd0);
        mon_en = 1'b0;

        // SAMPLE_DIV=4: ticks on edges 4, 8, 12 after Start; only samples driven at steps 2 and 6 are 1.
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start = (k == 0); abort = 1'b0; sig_en = 1'b1;
            sig_in = (k == 2) || (k == 6);
            pat_in = 3'b110; tgt_in = 10'd1; irq_en = 1'b0; irq_clr = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("div4_k%0d.sig_out", k), 32'(so4), 32'(k == 12));
            check($sformatf("div4_k%0d.count", k), 32'(cnt4), (k >= 12) ? 32'd1 : 32'd0);
            check($sformatf("div4_k%0d.done", k), 32'(done4), 32'(k >= 12));
            check($sformatf("div4_k%0d.busy", k), 32'(busy4), 32'(k < 12));
            check($sformatf("div4_k%0d.state", k), 32'(st4),
                  (k < 8) ? 32'(ARM) : (k < 12) ? 32'(RUN) : 32'(DON));
        end

        check("pulse_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
